palette_color_mapper: RTL and testbench
=======================================

// Module: palette_color_mapper
// PURPOSE
// - Pipelined, parametrised pixel colouriser between the per-ball hit detectors and the VGA output stage.
// - Resolves overlapping ball hits by fixed priority and looks up each ball's colour in a runtime-writable palette.
// - Renders a solid or gradient background and optionally blinks one selected ball on a frame-based timer.
// - Output is registered, 2-cycle latency, with a valid flag aligned to the pixel.
// PARAMETERS
// NUM_BALLS     8    number of ball hit inputs / palette entries (2..16)
// ID_W          $clog2(NUM_BALLS)  width of ball index
// COORD_W       10   width of DrawX/DrawY
// BLINK_FRAMES  30   frame_start pulses per blink half-period (>=1)
// PORTS
// Clk           in   1          system clock
// Reset         in   1          synchronous, active-high reset
// pix_valid     in   1          DrawX/DrawY/is_ball are valid this cycle
// is_ball       in   NUM_BALLS  bit i = current pixel lies inside ball i
// DrawX, DrawY  in   COORD_W    current pixel coordinates
// frame_start   in   1          one-cycle pulse at start of each frame
// bg_mode       in   1          0 = solid bg_color, 1 = horizontal gradient
// bg_color      in   24         {R,G,B} solid background colour
// blink_en      in   1          enable blinking of ball blink_id
// blink_id      in   ID_W       ball index to blink
// pal_we        in   1          palette write strobe
// pal_addr      in   ID_W       palette write index
// pal_data      in   24         palette write data {R,G,B}
// out_valid     out  1          VGA_R/G/B valid (pix_valid delayed 2 cycles)
// VGA_R, VGA_G, VGA_B  out  8   registered pixel colour
// BEHAVIOUR
// - Reset (sync, Reset=1 at posedge): out_valid=0, VGA_R/G/B=0, both pipeline stages cleared (valid=0, hit=0, id=0).
// - Reset also sets blink counter=0 and blink phase=ON.
// - Palette reset contents: idx0=9A0000, idx1=008808, idx2=00066F, idx3=FFFF00, all other entries FFFFFF.
// - Reset asserted mid-stream drops all in-flight pixels; no output with out_valid=1 for the 2 cycles after release.
// - Stage 1 (registered): s1_valid=pix_valid; s1_hit=|is_ball; s1_id=lowest index i with is_ball[i]=1 (ball 0 highest priority).
// - Stage 1 also registers s1_x=DrawX.
// - Stage 2 (registered outputs): out_valid=s1_valid.
//   - If s1_hit and NOT (blink_en && s1_id==blink_id && phase==OFF): colour = palette[s1_id].
//   - Otherwise colour = background.
// - Background: bg_mode=0 -> bg_color.
// - Background: bg_mode=1 -> each channel = 8'h46 - {1'b0,s1_x[9:3]}, saturating at 8'h00 (no wrap).
// - s1_x bits above COORD_W-1 are treated as zero.
// - When s1_valid=0, outputs are loaded with 0 (black); out_valid=0.
// - Palette write: entry pal_addr takes pal_data at the clock edge when pal_we=1.
// - pal_addr >= NUM_BALLS is ignored.
// - Write/read collision: if stage 2 reads the same entry being written in that cycle, the OLD value is output; the new value is used from the next cycle.
// - Blink timer: on each frame_start, if counter==BLINK_FRAMES-1 then counter<=0 and phase toggles; else counter++.
// - Blink timer runs regardless of blink_en.
// - blink_en=0: blinking is suppressed; the counter keeps running.
// - Simultaneous frame_start and pixel: the phase change affects only pixels whose stage-2 evaluation happens after that edge.
// - Input changes to bg_mode, bg_color and blink_* are sampled at stage 2 (not pipelined with the pixel).
// TESTING
// - Reset, then pix_valid=1, is_ball=8'h01 held -> out_valid rises in cycle 2 after release, RGB=9A,00,00.
// - Overlap: is_ball=8'b0000_1100 -> RGB=00,06,6F (ball 2 wins over ball 3).
// - is_ball=8'h80 with default palette -> FFFFFF.
// - Palette write pal_addr=5, pal_data=123456, then is_ball=8'h20 -> RGB=12,34,56.
// - Same-cycle write to entry 5 while entry 5 is in stage 2 -> old colour on that pixel, new colour on the next.
// - Background, is_ball=0: bg_mode=0, bg_color=102030 -> 10,20,30.
// - Background, is_ball=0: bg_mode=1, DrawX=0 -> 46,46,46.
// - Background, is_ball=0: bg_mode=1, DrawX=40 -> 41,41,41.
// - Background, is_ball=0: bg_mode=1, DrawX=639 -> 00,00,00 (saturated).
// - Blink: BLINK_FRAMES=2, blink_en=1, blink_id=1, is_ball=8'h02 -> ball colour for frames 0-1, background for frames 2-3, ball again at frame 4.
// - Reset pulsed while pixels are in flight -> out_valid=0 and RGB=0 on the next 2 edges, palette restored to reset values.

Source files
------------

// File: rtl/palette_color_mapper.sv
// Two-stage pixel colouriser: priority-resolves ball hits, looks up a writable
// palette and falls back to a solid or gradient background, with optional blinking.
module palette_color_mapper #(
  parameter int NUM_BALLS    = 8,
  parameter int ID_W         = $clog2(NUM_BALLS),
  parameter int COORD_W      = 10,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [NUM_BALLS-1:0] is_ball,
  input  logic [COORD_W-1:0]   DrawX,
  input  logic [COORD_W-1:0]   DrawY,
  input  logic                 frame_start,
  input  logic                 bg_mode,
  input  logic [23:0]          bg_color,
  input  logic                 blink_en,
  input  logic [ID_W-1:0]      blink_id,
  input  logic                 pal_we,
  input  logic [ID_W-1:0]      pal_addr,
  input  logic [23:0]          pal_data,
  output logic                 out_valid,
  output logic [7:0]           VGA_R,
  output logic [7:0]           VGA_G,
  output logic [7:0]           VGA_B
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [ID_W:0] NUM_BALLS_W = (ID_W + 1)'(NUM_BALLS);

  typedef enum logic {PHASE_OFF = 1'b0, PHASE_ON = 1'b1} phase_t;

  logic [23:0]      palette [NUM_BALLS];
  logic [CNT_W-1:0] blink_cnt;
  phase_t           phase;

  logic             s1_valid;
  logic             s1_hit;
  logic [ID_W-1:0]  s1_id;
  logic [9:0]       s1_x;

  logic [ID_W-1:0]  hit_id;
  logic [9:0]       x10;
  logic [7:0]       grad_sub;
  logic [7:0]       grad;
  logic             show_ball;
  logic [23:0]      colour;
  logic             unused_ok;

  function automatic logic [23:0] reset_color(input int idx);
    case (idx)
      0:       reset_color = 24'h9A0000;
      1:       reset_color = 24'h008808;
      2:       reset_color = 24'h00066F;
      3:       reset_color = 24'hFFFF00;
      default: reset_color = 24'hFFFFFF;
    endcase
  endfunction

  // The gradient only looks at a 10-bit X; narrower coordinates are zero-padded.
  generate
    if (COORD_W >= 10) begin : g_x_trunc
      assign x10 = DrawX[9:0];
    end else begin : g_x_pad
      assign x10 = {{(10 - COORD_W){1'b0}}, DrawX};
    end
  endgenerate

  assign unused_ok = ^{DrawY, DrawX, s1_x[2:0]};

  // Scanning downward leaves the lowest set index, so ball 0 wins overlaps.
  always_comb begin
    hit_id = '0;
    for (int i = NUM_BALLS - 1; i >= 0; i--) begin
      if (is_ball[i]) hit_id = ID_W'(i);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NUM_BALLS; i++) palette[i] <= reset_color(i);
    end else if (pal_we && ({1'b0, pal_addr} < NUM_BALLS_W)) begin
      palette[pal_addr] <= pal_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      blink_cnt <= '0;
      phase     <= PHASE_ON;
    end else if (frame_start) begin
      if (blink_cnt == CNT_LAST) begin
        blink_cnt <= '0;
        phase     <= (phase == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_hit   <= 1'b0;
      s1_id    <= '0;
      s1_x     <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_hit   <= |is_ball;
      s1_id    <= hit_id;
      s1_x     <= x10;
    end
  end

  // Palette is read before this edge's write lands, so a colliding write shows up one pixel later.
  always_comb begin
    grad_sub  = {1'b0, s1_x[9:3]};
    grad      = (grad_sub > 8'h46) ? 8'h00 : (8'h46 - grad_sub);
    show_ball = s1_hit && !(blink_en && (s1_id == blink_id) && (phase == PHASE_OFF));
    colour    = bg_mode ? {grad, grad, grad} : bg_color;
    if (show_ball) colour = palette[s1_id];
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      out_valid <= 1'b0;
      {VGA_R, VGA_G, VGA_B} <= '0;
    end else begin
      out_valid <= s1_valid;
      {VGA_R, VGA_G, VGA_B} <= s1_valid ? colour : 24'h000000;
    end
  end

endmodule

// File: tb/tb_palette_color_mapper.sv
// Directed bench for palette_color_mapper: hand-computed colours for priority,
// palette writes, backgrounds, blinking and reset behaviour.
module tb_palette_color_mapper;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [7:0]  is_ball;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        frame_start;
  logic        bg_mode;
  logic [23:0] bg_color;
  logic        blink_en;
  logic [2:0]  blink_id;
  logic        pal_we;
  logic [2:0]  pal_addr;
  logic [23:0] pal_data;
  logic        out_valid;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;

  int checks = 0;
  int errors = 0;

  palette_color_mapper #(
    .NUM_BALLS(8), .COORD_W(10), .BLINK_FRAMES(2)
  ) dut (
    .Clk(Clk), .Reset(Reset), .pix_valid(pix_valid), .is_ball(is_ball),
    .DrawX(DrawX), .DrawY(DrawY), .frame_start(frame_start),
    .bg_mode(bg_mode), .bg_color(bg_color), .blink_en(blink_en),
    .blink_id(blink_id), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .out_valid(out_valid),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got valid=%b rgb=%h, expected valid=%b rgb=%h",
               tag, got[24], got[23:0], exp[24], exp[23:0]);
    end
  endtask

  task automatic applyStimulus(input logic pv, input logic [7:0] balls, input logic [9:0] x);
    pix_valid = pv;
    is_ball   = balls;
    DrawX     = x;
    DrawY     = 10'd100;
  endtask

  task automatic pixelCheck(input string tag, input logic [7:0] balls, input logic [9:0] x,
                            input logic [23:0] exp_rgb);
    applyStimulus(1'b1, balls, x);
    tick();
    tick();
    checkOutput(tag, {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, exp_rgb});
  endtask

  task automatic framePulse();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    applyStimulus(1'b0, 8'h00, 10'd0);
    frame_start = 1'b0;
    bg_mode = 1'b0;
    bg_color = 24'h102030;
    blink_en = 1'b0;
    blink_id = 3'd0;
    pal_we = 1'b0;
    pal_addr = 3'd0;
    pal_data = 24'h0;
    tick();
    tick();
    checkOutput("reset_state", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);

    // Release with a ball-0 pixel already held: valid appears on the second edge.
    applyStimulus(1'b1, 8'h01, 10'd0);
    Reset = 1'b0;
    tick();
    checkOutput("release_edge1", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);
    tick();
    checkOutput("release_edge2", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h9A0000});

    pixelCheck("overlap_2_3", 8'b0000_1100, 10'd0, 24'h00066F);
    pixelCheck("overlap_0_1", 8'b0000_0011, 10'd0, 24'h9A0000);
    pixelCheck("ball7_default", 8'h80, 10'd0, 24'hFFFFFF);

    pal_we = 1'b1; pal_addr = 3'd5; pal_data = 24'h123456;
    tick();
    pal_we = 1'b0;
    pixelCheck("pal_write_5", 8'h20, 10'd0, 24'h123456);

    // Write entry 5 on the same edge that stage 2 consumes a ball-5 pixel.
    applyStimulus(1'b1, 8'h20, 10'd0);
    tick();
    pal_we = 1'b1; pal_addr = 3'd5; pal_data = 24'hABCDEF;
    tick();
    pal_we = 1'b0;
    checkOutput("collision_old", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'h123456});
    tick();
    checkOutput("collision_new", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hABCDEF});

    applyStimulus(1'b0, 8'h01, 10'd0);
    tick();
    tick();
    checkOutput("invalid_pixel", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);

    bg_mode = 1'b0; bg_color = 24'h102030;
    pixelCheck("bg_solid", 8'h00, 10'd0, 24'h102030);
    bg_mode = 1'b1;
    pixelCheck("grad_x0", 8'h00, 10'd0, 24'h464646);
    pixelCheck("grad_x40", 8'h00, 10'd40, 24'h414141);
    pixelCheck("grad_x559", 8'h00, 10'd559, 24'h010101);
    pixelCheck("grad_x560", 8'h00, 10'd560, 24'h000000);
    pixelCheck("grad_x639", 8'h00, 10'd639, 24'h000000);

    // Blink ball 1 with a two-frame half-period against a solid background.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    bg_mode = 1'b0; bg_color = 24'h102030;
    blink_en = 1'b1; blink_id = 3'd1;
    pixelCheck("blink_f0", 8'h02, 10'd0, 24'h008808);
    framePulse();
    pixelCheck("blink_f1", 8'h02, 10'd0, 24'h008808);
    framePulse();
    pixelCheck("blink_f2", 8'h02, 10'd0, 24'h102030);
    blink_en = 1'b0;
    pixelCheck("blink_disabled", 8'h02, 10'd0, 24'h008808);
    blink_en = 1'b1;
    pixelCheck("blink_other_ball", 8'h04, 10'd0, 24'h00066F);
    framePulse();
    pixelCheck("blink_f3", 8'h02, 10'd0, 24'h102030);
    framePulse();
    pixelCheck("blink_f4", 8'h02, 10'd0, 24'h008808);
    blink_en = 1'b0;

    // Dirty entry 5, then reset with pixels in flight.
    pal_we = 1'b1; pal_addr = 3'd5; pal_data = 24'h555555;
    tick();
    pal_we = 1'b0;
    applyStimulus(1'b1, 8'h20, 10'd0);
    tick();
    tick();
    Reset = 1'b1;
    tick();
    checkOutput("midreset_edge0", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);
    Reset = 1'b0;
    tick();
    checkOutput("midreset_edge1", {out_valid, VGA_R, VGA_G, VGA_B}, 25'h0);
    tick();
    checkOutput("midreset_pal5", {out_valid, VGA_R, VGA_G, VGA_B}, {1'b1, 24'hFFFFFF});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
